rgbw_sotp_gen: RTL

RGBW_SOTP_GEN -- requirements
Module: rgbw_sotp_gen

---
 rtl/rgbw_sotp_pkg.sv | 18 +
 rtl/rgbw_bit_timer.sv | 26 ++
 rtl/rgbw_sotp_gen.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rgbw_sotp_pkg.sv
// Shared types and default timing for the RGBW single-wire LED stream generator.
package rgbw_sotp_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HIGH    = 2'd1,
      LOW     = 2'd2,
      STR_RST = 2'd3
   } state_t;

   localparam int DEF_T0H         = 16;
   localparam int DEF_T0L         = 74;
   localparam int DEF_T1H         = 45;
   localparam int DEF_T1L         = 45;
   localparam int DEF_STR_RST     = 7681;
   localparam int DEF_COUNTER_MAX = 7800;

endpackage

// File: rtl/rgbw_bit_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
module rgbw_bit_timer #(
   parameter int               WIDTH   = 13,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   output logic             o_done
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst)
         r_cnt <= RST_VAL;
      else if (i_load)
         r_cnt <= i_load_val;
      else if (r_cnt != '0)
         r_cnt <= r_cnt - 1'b1;
   end

   assign o_done = (r_cnt == '0);

endmodule

// File: rtl/rgbw_sotp_gen.sv
// Serialises FIFO words MSB-first as RGBW LED pulses, with frame latch handling.
// Define RGBW_SOTP_INVERT_EN to invert out_sig for inverting level shifters.
module rgbw_sotp_gen
   import rgbw_sotp_pkg::*;
#(
   parameter int DATA_SIZE        = 32,
   parameter int WORD_BITS        = 32,
   parameter int RGBW_T0H         = DEF_T0H,
   parameter int RGBW_T0L         = DEF_T0L,
   parameter int RGBW_T1H         = DEF_T1H,
   parameter int RGBW_T1L         = DEF_T1L,
   parameter int RGBW_STR_RST     = DEF_STR_RST,
   parameter int PIXELS_PER_FRAME = 0,
   parameter int COUNTER_MAX      = DEF_COUNTER_MAX
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_rd_fifo_empty,
   input  logic [DATA_SIZE-1:0] in_rd_fifo_data,
   output logic                 out_rd_fifo_en,
   output logic                 out_sig,
   output logic                 out_busy,
   output logic                 out_underrun
);

   localparam int TW  = $clog2(COUNTER_MAX + 1);
   localparam int PCW = (PIXELS_PER_FRAME == 0) ? 1 : $clog2(PIXELS_PER_FRAME + 1);
   localparam int BCW = (WORD_BITS <= 1) ? 1 : $clog2(WORD_BITS);

   // Timer counts down to zero inclusive, so each phase loads length-1.
   localparam logic [TW-1:0] L_T0H = TW'(RGBW_T0H - 1);
   localparam logic [TW-1:0] L_T0L = TW'(RGBW_T0L - 1);
   localparam logic [TW-1:0] L_T1H = TW'(RGBW_T1H - 1);
   localparam logic [TW-1:0] L_T1L = TW'(RGBW_T1L - 1);
   localparam logic [TW-1:0] L_STR = TW'(RGBW_STR_RST - 1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [WORD_BITS-1:0]   r_shift;
   logic [BCW-1:0]         r_bit_idx;
   logic [PCW-1:0]         r_pix;
   logic                   r_underrun;

   logic                   w_tmr_load;
   logic [TW-1:0]          w_tmr_val;
   logic                   w_tmr_done;
   logic                   w_pop;
   logic                   w_shift_step;
   logic                   w_pix_inc;
   logic                   w_pix_clr;
   logic                   w_underrun_nxt;
   logic [WORD_BITS-1:0]   w_word_in;
   logic [WORD_BITS-1:0]   w_shift_sh;
   logic [PCW-1:0]         w_pix_inc_val;
   logic                   w_frame_done;
   logic                   w_sig;
   logic                   w_unused_data;

   assign w_word_in     = in_rd_fifo_data[WORD_BITS-1:0];
   assign w_unused_data = ^in_rd_fifo_data;
   assign w_shift_sh    = r_shift << 1;
   assign w_pix_inc_val = r_pix + 1'b1;
   assign w_frame_done  = (PIXELS_PER_FRAME != 0) && (w_pix_inc_val == PCW'(PIXELS_PER_FRAME));

   rgbw_bit_timer #(
      .WIDTH   (TW),
      .RST_VAL (L_STR)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_done     (w_tmr_done)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_tmr_load     = 1'b0;
      w_tmr_val      = L_STR;
      w_pop          = 1'b0;
      w_shift_step   = 1'b0;
      w_pix_inc      = 1'b0;
      w_pix_clr      = 1'b0;
      w_underrun_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (!in_rd_fifo_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = HIGH;
               w_tmr_load  = 1'b1;
               w_tmr_val   = w_word_in[WORD_BITS-1] ? L_T1H : L_T0H;
            end
         end
         HIGH: begin
            if (w_tmr_done) begin
               w_state_nxt = LOW;
               w_tmr_load  = 1'b1;
               w_tmr_val   = r_shift[WORD_BITS-1] ? L_T1L : L_T0L;
            end
         end
         LOW: begin
            if (w_tmr_done) begin
               if (r_bit_idx != '0) begin
                  w_shift_step = 1'b1;
                  w_state_nxt  = HIGH;
                  w_tmr_load   = 1'b1;
                  w_tmr_val    = w_shift_sh[WORD_BITS-1] ? L_T1H : L_T0H;
               end else begin
                  // Word boundary: frame end wins over a waiting word.
                  w_pix_inc = 1'b1;
                  if (w_frame_done) begin
                     w_state_nxt = STR_RST;
                     w_tmr_load  = 1'b1;
                     w_tmr_val   = L_STR;
                  end else if (!in_rd_fifo_empty) begin
                     w_pop       = 1'b1;
                     w_state_nxt = HIGH;
                     w_tmr_load  = 1'b1;
                     w_tmr_val   = w_word_in[WORD_BITS-1] ? L_T1H : L_T0H;
                  end else begin
                     w_state_nxt    = STR_RST;
                     w_tmr_load     = 1'b1;
                     w_tmr_val      = L_STR;
                     w_underrun_nxt = (PIXELS_PER_FRAME != 0);
                  end
               end
            end
         end
         STR_RST: begin
            if (w_tmr_done) begin
               w_pix_clr   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = STR_RST;
            w_tmr_load  = 1'b1;
            w_tmr_val   = L_STR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= STR_RST;
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_pix      <= '0;
         r_underrun <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_underrun <= w_underrun_nxt;
         if (w_pop) begin
            r_shift   <= w_word_in;
            r_bit_idx <= BCW'(WORD_BITS - 1);
         end else if (w_shift_step) begin
            r_shift   <= w_shift_sh;
            r_bit_idx <= r_bit_idx - 1'b1;
         end
         if (w_pix_clr)
            r_pix <= '0;
         else if (w_pix_inc)
            r_pix <= w_pix_inc_val;
      end
   end

   assign w_sig          = (r_state == HIGH);
   assign out_busy       = (r_state != IDLE);
   assign out_rd_fifo_en = w_pop;
   assign out_underrun   = r_underrun;

`ifdef RGBW_SOTP_INVERT_EN
   assign out_sig = ~w_sig;
`else
   assign out_sig = w_sig;
`endif

endmodule
